mux41_rr_arbiter: RTL

Round-robin arbiter that shares the 4x1 decoder/tri-state mux between four requesters. It samples four request lines, grants the mux to exactly one owner at a time, and drives the mux `sel` and `en` pins directly from registered state. When no grant is active, `en` is low and the mux output floats (Z). A hold limit prevents one requester from holding the mux indefinitely while others wait.

---
 rtl/mux41_rr_arbiter.sv | 115 +++++++++++
 1 files changed

// File: rtl/mux41_rr_arbiter.sv
// Round-robin owner of the shared 4x1 decoder/tri-state mux: one-hot grant, mux sel/en, handoff pulse.
// One-cycle latency from req to every output, all outputs straight from flops; hold limit bounds tenure under contention.
module mux41_rr_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       en,
    output logic       switch
);

    localparam int CW = $clog2(MAX_HOLD);
    localparam logic [CW-1:0] HOLD_LIMIT = CW'(MAX_HOLD - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state_q, state_d;
    logic [1:0]      owner_q, owner_d;
    logic [1:0]      last_q, last_d;
    logic [CW-1:0]   hold_cnt_q, hold_cnt_d;
    logic [3:0]      gnt_q, gnt_d;
    logic            en_q, en_d;
    logic            switch_q, switch_d;
    logic [3:0]      others;

    // First requester at or after position p, wrapping modulo 4.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] pick;
        logic [1:0] idx;
        logic       found;
        pick  = p;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = p + 2'(i);
            if (!found && r[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        hold_cnt_d = hold_cnt_q;
        switch_d   = 1'b0;
        others     = req & ~(4'b0001 << owner_q);

        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d    = GRANT;
                    owner_d    = rr_pick(req, last_q + 2'd1);
                    hold_cnt_d = '0;
                end
            end
            GRANT: begin
                if (!req[owner_q]) begin
                    if (|others) begin
                        owner_d    = rr_pick(others, owner_q + 2'd1);
                        hold_cnt_d = '0;
                        switch_d   = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if ((hold_cnt_q == HOLD_LIMIT) && (|others)) begin
                    // Preempt: owner is masked out of the search so it cannot win again.
                    owner_d    = rr_pick(others, owner_q + 2'd1);
                    hold_cnt_d = '0;
                    switch_d   = 1'b1;
                end else if (hold_cnt_q != HOLD_LIMIT) begin
                    hold_cnt_d = hold_cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d == GRANT) begin
            last_d = owner_d;
        end
        gnt_d = (state_d == GRANT) ? (4'b0001 << owner_d) : 4'b0000;
        en_d  = (state_d == GRANT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= 2'd0;
            last_q     <= 2'd3;
            hold_cnt_q <= '0;
            gnt_q      <= 4'b0000;
            en_q       <= 1'b0;
            switch_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            hold_cnt_q <= hold_cnt_d;
            gnt_q      <= gnt_d;
            en_q       <= en_d;
            switch_q   <= switch_d;
        end
    end

    assign gnt    = gnt_q;
    assign sel    = owner_q;
    assign en     = en_q;
    assign switch = switch_q;

endmodule
